// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl (with codes_pkg)
// Brief    : RV32 ALU control decoder with combinational and ID/EX-registered
//            outputs plus an unsupported-encoding flag.
// Revision : 1.0 - initial release
// ============================================================================

package codes_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_control_t;
endpackage

module alu_ctrl
    import codes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] alu_op,
    input  logic       bit_30,
    input  logic [2:0] funct3,
    output logic [3:0] control,
    output logic       illegal,
    output logic [3:0] control_q,
    output logic       illegal_q
);

    localparam logic [1:0] c_op_mem    = 2'b00;
    localparam logic [1:0] c_op_branch = 2'b01;
    localparam logic [1:0] c_op_rtype  = 2'b10;
    localparam logic [1:0] c_op_itype  = 2'b11;

    alu_control_t w_control;
    logic         w_illegal;
    alu_control_t r_control_q;
    logic         r_illegal_q;

    always_comb begin
        w_control = ALU_ADD;
        w_illegal = 1'b1;
        // Parity of all inputs is only unknown when some input is X/Z, so the
        // fall-through leaves the safe ADD/illegal default in place.
        case (^{alu_op, bit_30, funct3})
            1'b0, 1'b1: begin
                case (alu_op)
                    c_op_mem: begin
                        w_control = ALU_ADD;
                        w_illegal = 1'b0;
                    end
                    c_op_branch: begin
                        w_illegal = 1'b0;
                        case (funct3)
                            3'b000, 3'b001: w_control = ALU_SUB;
                            3'b100, 3'b101: w_control = ALU_SLT;
                            3'b110, 3'b111: w_control = ALU_SLTU;
                            default: begin
                                w_control = ALU_SUB;
                                w_illegal = 1'b1;
                            end
                        endcase
                    end
                    c_op_rtype, c_op_itype: begin
                        w_illegal = bit_30;
                        case (funct3)
                            3'b000: begin
                                w_control = (bit_30 && (alu_op == c_op_rtype)) ? ALU_SUB : ALU_ADD;
                                w_illegal = 1'b0;
                            end
                            3'b101: begin
                                w_control = bit_30 ? ALU_SRA : ALU_SRL;
                                w_illegal = 1'b0;
                            end
                            3'b001:  w_control = ALU_SLL;
                            3'b010:  w_control = ALU_SLT;
                            3'b011:  w_control = ALU_SLTU;
                            3'b100:  w_control = ALU_XOR;
                            3'b110:  w_control = ALU_OR;
                            default: w_control = ALU_AND;
                        endcase
                    end
                    default: begin
                        w_control = ALU_ADD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                w_control = ALU_ADD;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_control_q <= ALU_ADD;
            r_illegal_q <= 1'b0;
        end else if (en) begin
            r_control_q <= w_control;
            r_illegal_q <= w_illegal;
        end
    end

    assign control   = w_control;
    assign illegal   = w_illegal;
    assign control_q = r_control_q;
    assign illegal_q = r_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl
// Brief    : Directed self-checking bench for alu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl;

    localparam logic [3:0] c_add  = 4'd0;
    localparam logic [3:0] c_sub  = 4'd1;
    localparam logic [3:0] c_and  = 4'd2;
    localparam logic [3:0] c_or   = 4'd3;
    localparam logic [3:0] c_xor  = 4'd4;
    localparam logic [3:0] c_sll  = 4'd5;
    localparam logic [3:0] c_srl  = 4'd6;
    localparam logic [3:0] c_sra  = 4'd7;
    localparam logic [3:0] c_slt  = 4'd8;
    localparam logic [3:0] c_sltu = 4'd9;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] alu_op;
    logic       bit_30;
    logic [2:0] funct3;
    logic [3:0] control;
    logic       illegal;
    logic [3:0] control_q;
    logic       illegal_q;

    int checks   = 0;
    int failures = 0;

    alu_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .alu_op    (alu_op),
        .bit_30    (bit_30),
        .funct3    (funct3),
        .control   (control),
        .illegal   (illegal),
        .control_q (control_q),
        .illegal_q (illegal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [1:0] op, input logic b30,
                        input logic [2:0] f3, input logic [3:0] exp_c, input logic exp_i);
        alu_op = op;
        bit_30 = b30;
        funct3 = f3;
        #0;
        chk({tag, "_ctl"}, control, exp_c);
        chk({tag, "_ill"}, {3'b000, illegal}, {3'b000, exp_i});
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        alu_op = 2'b00;
        bit_30 = 1'b0;
        funct3 = 3'b000;
        #12;
        chk("rst_ctl_q", control_q, c_add);
        chk("rst_ill_q", {3'b000, illegal_q}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational decode, hand-computed expectations
        comb("mem_add",     2'b00, 1'b0, 3'b000, c_add,  1'b0);
        comb("mem_any",     2'b00, 1'b1, 3'b111, c_add,  1'b0);
        comb("br_beq",      2'b01, 1'b0, 3'b000, c_sub,  1'b0);
        comb("br_bne_b30",  2'b01, 1'b1, 3'b001, c_sub,  1'b0);
        comb("br_blt",      2'b01, 1'b0, 3'b100, c_slt,  1'b0);
        comb("br_bge",      2'b01, 1'b0, 3'b101, c_slt,  1'b0);
        comb("br_bltu",     2'b01, 1'b0, 3'b110, c_sltu, 1'b0);
        comb("br_bgeu",     2'b01, 1'b0, 3'b111, c_sltu, 1'b0);
        comb("br_bad010",   2'b01, 1'b0, 3'b010, c_sub,  1'b1);
        comb("br_bad011",   2'b01, 1'b1, 3'b011, c_sub,  1'b1);
        comb("r_add",       2'b10, 1'b0, 3'b000, c_add,  1'b0);
        comb("r_sub",       2'b10, 1'b1, 3'b000, c_sub,  1'b0);
        comb("r_sll",       2'b10, 1'b0, 3'b001, c_sll,  1'b0);
        comb("r_slt",       2'b10, 1'b0, 3'b010, c_slt,  1'b0);
        comb("r_sltu",      2'b10, 1'b0, 3'b011, c_sltu, 1'b0);
        comb("r_xor",       2'b10, 1'b0, 3'b100, c_xor,  1'b0);
        comb("r_srl",       2'b10, 1'b0, 3'b101, c_srl,  1'b0);
        comb("r_sra",       2'b10, 1'b1, 3'b101, c_sra,  1'b0);
        comb("r_or",        2'b10, 1'b0, 3'b110, c_or,   1'b0);
        comb("r_and",       2'b10, 1'b0, 3'b111, c_and,  1'b0);
        comb("r_and_b30",   2'b10, 1'b1, 3'b111, c_and,  1'b1);
        comb("r_sll_b30",   2'b10, 1'b1, 3'b001, c_sll,  1'b1);
        comb("i_addi_b30",  2'b11, 1'b1, 3'b000, c_add,  1'b0);
        comb("i_addi",      2'b11, 1'b0, 3'b000, c_add,  1'b0);
        comb("i_srli",      2'b11, 1'b0, 3'b101, c_srl,  1'b0);
        comb("i_srai",      2'b11, 1'b1, 3'b101, c_sra,  1'b0);
        comb("i_slti_b30",  2'b11, 1'b1, 3'b010, c_slt,  1'b1);
        comb("i_xori",      2'b11, 1'b0, 3'b100, c_xor,  1'b0);
        comb("i_ori_b30",   2'b11, 1'b1, 3'b110, c_or,   1'b1);

        // Registered path: load, stall, reload
        @(negedge clk);
        en = 1'b1; alu_op = 2'b10; bit_30 = 1'b1; funct3 = 3'b000;
        @(posedge clk); #1;
        chk("q_load_sub", control_q, c_sub);
        chk("q_load_ill", {3'b000, illegal_q}, 4'd0);
        @(negedge clk);
        en = 1'b0; bit_30 = 1'b0; funct3 = 3'b111;
        @(posedge clk); #1;
        chk("q_hold1", control_q, c_sub);
        @(posedge clk); #1;
        chk("q_hold2", control_q, c_sub);
        @(negedge clk);
        en = 1'b1; bit_30 = 1'b1;
        @(posedge clk); #1;
        chk("q_and_ctl", control_q, c_and);
        chk("q_and_ill", {3'b000, illegal_q}, 4'd1);
        @(negedge clk);
        bit_30 = 1'b1; funct3 = 3'b000;
        @(posedge clk); #1;
        chk("q_sub2", control_q, c_sub);
        chk("q_sub2_ill", {3'b000, illegal_q}, 4'd0);

        // Asynchronous reset between edges, overriding en
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl_q", control_q, c_add);
        chk("arst_ill_q", {3'b000, illegal_q}, 4'd0);
        @(posedge clk); #1;
        chk("arst_hold", control_q, c_add);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_noen", control_q, c_add);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_load", control_q, c_sub);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
